// File: rtl/sdram_protocol_monitor.sv
// sdram_protocol_monitor
// Passive checker for the controller-to-SDRAM command pins. It tracks the power-up init
// sequence, per-bank open/close state, tRP/tRCD/tRFC, the refresh interval and CAS-latency
// read-data timing. Each violation sets a sticky bit and bumps a saturating count. The
// lowest bit detected first is latched as a code.
// err_vec bits: 0 INIT, 1 TRP, 2 TRCD, 3 CLOSED, 4 OPEN, 5 TRFC, 6 RFSH, 7 CAS.
// Optional build macro: SDRAM_MON_DISPLAY_EN adds a simulation-only $error report on every
// detection. Register behaviour is the same with or without it.

module sdram_protocol_monitor #(
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned BA_W      = 2,
    parameter int unsigned INIT_NOP  = 10000,
    parameter int unsigned TRP       = 2,
    parameter int unsigned TRCD      = 2,
    parameter int unsigned TRFC      = 7,
    parameter int unsigned RFSH_MAX  = 256,
    parameter int unsigned TMR_W     = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             sdram_clk,
    input  logic             sdram_rst_n,
    input  logic             sdram_cs_n,
    input  logic             sdram_ras_n,
    input  logic             sdram_cas_n,
    input  logic             sdram_we_n,
    input  logic [BA_W-1:0]  sdram_ba,
    input  logic             sdram_a10,
    input  logic             sdram_rd_valid,
    input  logic [2:0]       cfg_cas,
    input  logic             err_clr,
    output logic             init_done,
    output logic [7:0]       err_vec,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       first_err,
    output logic             first_err_vld
);

    // {ras_n, cas_n, we_n} encodings
    localparam logic [2:0] CmdMrs = 3'b000;
    localparam logic [2:0] CmdRef = 3'b001;
    localparam logic [2:0] CmdPre = 3'b010;
    localparam logic [2:0] CmdAct = 3'b011;
    localparam logic [2:0] CmdWr  = 3'b100;
    localparam logic [2:0] CmdRd  = 3'b101;
    localparam logic [2:0] CmdNop = 3'b111;

    typedef enum logic [2:0] {
        StPwr, StWaitPre, StWaitRef1, StWaitRef2, StWaitMrs, StRun
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           cmd;
    logic                 is_nop;
    logic                 run;
    logic                 init_err;
    logic                 init_ok;

    logic [TMR_W-1:0]     init_cnt_q, init_cnt_d;
    logic [NUM_BANKS-1:0] open_q, open_d;
    logic [TMR_W-1:0]     pre_tmr_q [NUM_BANKS];
    logic [TMR_W-1:0]     pre_tmr_d [NUM_BANKS];
    logic [TMR_W-1:0]     act_tmr_q [NUM_BANKS];
    logic [TMR_W-1:0]     act_tmr_d [NUM_BANKS];
    logic [TMR_W-1:0]     rfc_tmr_q, rfc_tmr_d;
    logic [TMR_W-1:0]     rfsh_tmr_q, rfsh_tmr_d;
    logic                 rfsh_on_q, rfsh_on_d;
    logic                 rfsh_armed_q, rfsh_armed_d;
    logic [3:0]           rd_sr_q, rd_sr_d;
    logic [1:0]           cas_idx;
    logic                 cas_ok;

    logic [7:0]           det;
    logic [7:0]           err_vec_q, err_vec_d, vec_base;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d, cnt_base;
    logic [CNT_W:0]       cnt_sum;
    logic [3:0]           det_num;
    logic [2:0]           det_low;
    logic [2:0]           first_err_q, first_err_d;
    logic                 vld_q, vld_d, vld_base;

    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        return (&v) ? v : v + TMR_W'(1);
    endfunction

    // Deselected chip is indistinguishable from NOP.
    assign cmd     = sdram_cs_n ? CmdNop : {sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign is_nop  = (cmd == CmdNop);
    assign init_ok = (init_cnt_q >= TMR_W'(INIT_NOP));

    // Init FSM state register
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q <= StPwr;
        end else begin
            state_q <= state_d;
        end
    end

    // Init FSM next state: illegal commands hold the state except in PWR
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StPwr: begin
                if (!is_nop) state_d = (cmd == CmdPre && init_ok) ? StWaitRef1 : StWaitPre;
            end
            StWaitPre:  if (cmd == CmdPre) state_d = StWaitRef1;
            StWaitRef1: if (cmd == CmdRef) state_d = StWaitRef2;
            StWaitRef2: if (cmd == CmdRef) state_d = StWaitMrs;
            StWaitMrs:  if (cmd == CmdMrs) state_d = StRun;
            StRun:      state_d = StRun;
            default:    state_d = StPwr;
        endcase
    end

    // Init FSM outputs: init_done and init-sequence violations
    always_comb begin
        run      = (state_q == StRun);
        init_err = 1'b0;
        unique case (state_q)
            StPwr:      init_err = !is_nop && !(cmd == CmdPre && init_ok);
            StWaitPre:  init_err = !is_nop && (cmd != CmdPre);
            StWaitRef1: init_err = !is_nop && (cmd != CmdRef);
            StWaitRef2: init_err = !is_nop && (cmd != CmdRef);
            StWaitMrs:  init_err = !is_nop && (cmd != CmdMrs);
            default:    init_err = 1'b0;
        endcase
    end

    assign init_done = run;

    // Next-state for bank state, timing timers and the read-marker shift register
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (state_q == StPwr && is_nop) init_cnt_d = sat_inc(init_cnt_q);

        open_d = open_q;
        for (int b = 0; b < NUM_BANKS; b++) begin
            pre_tmr_d[b] = sat_inc(pre_tmr_q[b]);
            act_tmr_d[b] = sat_inc(act_tmr_q[b]);
            if (cmd == CmdPre && (sdram_a10 || sdram_ba == BA_W'(b))) begin
                pre_tmr_d[b] = TMR_W'(1);
                open_d[b]    = 1'b0;
            end
            if (cmd == CmdAct && sdram_ba == BA_W'(b)) begin
                act_tmr_d[b] = TMR_W'(1);
                open_d[b]    = 1'b1;
            end
        end

        rfc_tmr_d = (cmd == CmdRef) ? TMR_W'(1) : sat_inc(rfc_tmr_q);

        // Interval timer only runs once the second init REF has been seen.
        rfsh_on_d = rfsh_on_q | (state_q == StWaitRef2 && cmd == CmdRef);
        if (cmd == CmdRef) begin
            rfsh_tmr_d   = TMR_W'(1);
            rfsh_armed_d = 1'b1;
        end else begin
            rfsh_tmr_d   = rfsh_on_q ? sat_inc(rfsh_tmr_q) : rfsh_tmr_q;
            rfsh_armed_d = rfsh_armed_q && (rfsh_tmr_q != TMR_W'(RFSH_MAX));
        end

        // rd_sr_q[k] set means a READ was sampled k+1 cycles ago.
        rd_sr_d = {rd_sr_q[2:0], cmd == CmdRd};
    end

    // Bank state and timer registers
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            init_cnt_q   <= '0;
            open_q       <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                pre_tmr_q[b] <= '1;
                act_tmr_q[b] <= '1;
            end
            rfc_tmr_q    <= '1;
            rfsh_tmr_q   <= '0;
            rfsh_on_q    <= 1'b0;
            rfsh_armed_q <= 1'b0;
            rd_sr_q      <= '0;
        end else begin
            init_cnt_q   <= init_cnt_d;
            open_q       <= open_d;
            for (int b = 0; b < NUM_BANKS; b++) begin
                pre_tmr_q[b] <= pre_tmr_d[b];
                act_tmr_q[b] <= act_tmr_d[b];
            end
            rfc_tmr_q    <= rfc_tmr_d;
            rfsh_tmr_q   <= rfsh_tmr_d;
            rfsh_on_q    <= rfsh_on_d;
            rfsh_armed_q <= rfsh_armed_d;
            rd_sr_q      <= rd_sr_d;
        end
    end

    assign cas_ok  = (cfg_cas == 3'd2) || (cfg_cas == 3'd3);
    assign cas_idx = cfg_cas[1:0] - 2'd1;

    // Violation detection against pre-command bank state
    always_comb begin
        det    = '0;
        det[0] = init_err;
        if (run) begin
            unique case (cmd)
                CmdAct: begin
                    det[1] = (pre_tmr_q[sdram_ba] < TMR_W'(TRP));
                    det[4] = open_q[sdram_ba];
                end
                CmdRd, CmdWr: begin
                    det[2] = (act_tmr_q[sdram_ba] < TMR_W'(TRCD));
                    det[3] = !open_q[sdram_ba];
                end
                CmdRef:  det[4] = |open_q;
                default: det[4] = 1'b0;
            endcase
            det[5] = !is_nop && (rfc_tmr_q < TMR_W'(TRFC));
            det[6] = rfsh_on_q && rfsh_armed_q && (rfsh_tmr_q == TMR_W'(RFSH_MAX));
            det[7] = cas_ok ? (sdram_rd_valid != rd_sr_q[cas_idx]) : 1'b1;
        end
    end

    // Error bookkeeping next state; a same-cycle detection lands on top of err_clr
    always_comb begin
        vec_base  = err_clr ? '0 : err_vec_q;
        cnt_base  = err_clr ? '0 : err_cnt_q;
        vld_base  = err_clr ? 1'b0 : vld_q;
        err_vec_d = vec_base | det;

        det_num = '0;
        det_low = '0;
        for (int i = 7; i >= 0; i--) begin
            det_num = det_num + {3'b000, det[i]};
            if (det[i]) det_low = 3'(i);
        end
        cnt_sum   = {1'b0, cnt_base} + (CNT_W + 1)'(det_num);
        err_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

        first_err_d = first_err_q;
        vld_d       = vld_base;
        if (!vld_base && (|det)) begin
            first_err_d = det_low;
            vld_d       = 1'b1;
        end
    end

    // Error registers
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            err_vec_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            vld_q       <= 1'b0;
        end else begin
            err_vec_q   <= err_vec_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            vld_q       <= vld_d;
        end
    end

    assign err_vec       = err_vec_q;
    assign err_cnt       = err_cnt_q;
    assign first_err     = first_err_q;
    assign first_err_vld = vld_q;

`ifdef SDRAM_MON_DISPLAY_EN
    function automatic string err_name(input int idx);
        case (idx)
            0:       return "INIT";
            1:       return "TRP";
            2:       return "TRCD";
            3:       return "CLOSED";
            4:       return "OPEN";
            5:       return "TRFC";
            6:       return "RFSH";
            default: return "CAS";
        endcase
    endfunction

    // Simulation-only report of every detection
    always @(posedge sdram_clk) begin
        if (sdram_rst_n) begin
            for (int i = 0; i < 8; i++) begin
                if (det[i]) $error("%0t sdram_protocol_monitor: %s error, bank %0d",
                                   $time, err_name(i), sdram_ba);
            end
        end
    end
`else
    // Silent build: violations are visible only through the error registers.
`endif

endmodule

// File: tb/tb_sdram_protocol_monitor.sv
// Directed bench for sdram_protocol_monitor: init sequence, bank timing, CAS timing,
// refresh interval, error clear and asynchronous reset.

module tb_sdram_protocol_monitor;

    localparam logic [2:0] NOP = 3'b111;
    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;
    localparam logic [2:0] MRS = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        ras_n = 1'b1;
    logic        cas_n = 1'b1;
    logic        we_n = 1'b1;
    logic [1:0]  ba = 2'd0;
    logic        a10 = 1'b0;
    logic        rd_valid = 1'b0;
    logic [2:0]  cfg_cas = 3'd2;
    logic        err_clr = 1'b0;
    logic        init_done;
    logic [7:0]  err_vec;
    logic [15:0] err_cnt;
    logic [2:0]  first_err;
    logic        first_err_vld;

    int          total = 0;
    int          bad = 0;
    logic        auto_rv = 1'b1;
    logic        man_rv = 1'b0;
    logic [3:0]  rd_hist = 4'd0;

    sdram_protocol_monitor dut (
        .sdram_clk      (clk),
        .sdram_rst_n    (rst_n),
        .sdram_cs_n     (cs_n),
        .sdram_ras_n    (ras_n),
        .sdram_cas_n    (cas_n),
        .sdram_we_n     (we_n),
        .sdram_ba       (ba),
        .sdram_a10      (a10),
        .sdram_rd_valid (rd_valid),
        .cfg_cas        (cfg_cas),
        .err_clr        (err_clr),
        .init_done      (init_done),
        .err_vec        (err_vec),
        .err_cnt        (err_cnt),
        .first_err      (first_err),
        .first_err_vld  (first_err_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // One command cycle; rd_valid follows issued READs unless auto_rv is off.
    task automatic tick(input logic [2:0] c, input logic [1:0] b, input logic a);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = c;
        ba  = b;
        a10 = a;
        if (auto_rv) rd_valid = (cfg_cas == 3'd3) ? rd_hist[2] : rd_hist[1];
        else         rd_valid = man_rv;
        @(posedge clk);
        #1;
        rd_hist = {rd_hist[2:0], c == RD};
        err_clr = 1'b0;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) tick(NOP, 2'd0, 1'b0);
    endtask

    // Deselected cycles carrying an MRS pattern on the pins.
    task automatic inhibit(input int n);
        for (int i = 0; i < n; i++) begin
            cs_n = 1'b1;
            {ras_n, cas_n, we_n} = MRS;
            rd_valid = 1'b0;
            @(posedge clk);
            #1;
            rd_hist = {rd_hist[2:0], 1'b0};
        end
    endtask

    task automatic refresh();
        tick(REF, 2'd0, 1'b0);
        nops(7);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cs_n = 1'b1;
        err_clr = 1'b0;
        rd_valid = 1'b0;
        rd_hist = 4'd0;
        auto_rv = 1'b1;
        cfg_cas = 3'd2;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({init_done, err_vec, err_cnt, first_err, first_err_vld} !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs: got done=%b vec=%h cnt=%0d fe=%0d vld=%b want all 0",
                     init_done, err_vec, err_cnt, first_err, first_err_vld);
        end
        do_reset();
        inhibit(3);
        total++;
        if ({init_done, err_vec, err_cnt, first_err_vld} !== 26'd0) begin
            bad++;
            $display("FAIL reset_release: got done=%b vec=%h cnt=%0d vld=%b want all 0",
                     init_done, err_vec, err_cnt, first_err_vld);
        end
    endtask

    task automatic test_init_boundary();
        do_reset();
        inhibit(4999);
        nops(5000);
        tick(PRE, 2'd0, 1'b1);
        total++;
        if (err_vec !== 8'h01 || err_cnt !== 16'd1) begin
            bad++;
            $display("FAIL init_pre_early: got vec=%h cnt=%0d want vec=01 cnt=1", err_vec, err_cnt);
        end
    endtask

    task automatic test_early_act();
        do_reset();
        nops(50);
        tick(ACT, 2'd0, 1'b0);
        total++;
        if (err_vec !== 8'h01 || err_cnt !== 16'd1 || first_err !== 3'd0 || first_err_vld !== 1'b1)
        begin
            bad++;
            $display("FAIL early_act: got vec=%h cnt=%0d fe=%0d vld=%b want 01 1 0 1",
                     err_vec, err_cnt, first_err, first_err_vld);
        end
        tick(RD, 2'd1, 1'b0);
        total++;
        if (err_cnt !== 16'd2 || init_done !== 1'b0) begin
            bad++;
            $display("FAIL wait_pre_read: got cnt=%0d done=%b want cnt=2 done=0", err_cnt, init_done);
        end
        tick(PRE, 2'd0, 1'b1);
        tick(MRS, 2'd0, 1'b0);
        total++;
        if (err_cnt !== 16'd3 || err_vec !== 8'h01) begin
            bad++;
            $display("FAIL wait_ref1_mrs: got cnt=%0d vec=%h want cnt=3 vec=01", err_cnt, err_vec);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (err_vec !== 8'h00 || err_cnt !== 16'd0 || first_err_vld !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got vec=%h cnt=%0d vld=%b want 00 0 0",
                     err_vec, err_cnt, first_err_vld);
        end
    endtask

    task automatic test_init_legal();
        do_reset();
        nops(10000);
        tick(PRE, 2'd0, 1'b1);
        nops(3);
        tick(REF, 2'd0, 1'b0);
        nops(7);
        tick(REF, 2'd0, 1'b0);
        nops(7);
        total++;
        if (init_done !== 1'b0) begin
            bad++;
            $display("FAIL init_before_mrs: got done=%b want 0", init_done);
        end
        tick(MRS, 2'd0, 1'b0);
        total++;
        if (init_done !== 1'b1 || err_vec !== 8'h00 || err_cnt !== 16'd0 || first_err_vld !== 1'b0)
        begin
            bad++;
            $display("FAIL init_legal: got done=%b vec=%h cnt=%0d vld=%b want 1 00 0 0",
                     init_done, err_vec, err_cnt, first_err_vld);
        end
    endtask

    task automatic test_bank_timing();
        refresh();
        tick(ACT, 2'd1, 1'b0);
        total++;
        if (err_vec !== 8'h00) begin
            bad++;
            $display("FAIL run_ref_act: got vec=%h want 00", err_vec);
        end
        tick(RD, 2'd1, 1'b0);
        total++;
        if (err_vec !== 8'h04) begin
            bad++;
            $display("FAIL trcd_read: got vec=%h want 04", err_vec);
        end
        tick(RD, 2'd2, 1'b0);
        total++;
        if (err_vec !== 8'h0C || err_cnt !== 16'd2 || first_err !== 3'd2) begin
            bad++;
            $display("FAIL closed_read: got vec=%h cnt=%0d fe=%0d want 0c 2 2",
                     err_vec, err_cnt, first_err);
        end
        nops(4);
        tick(ACT, 2'd3, 1'b0);
        tick(NOP, 2'd0, 1'b0);
        tick(WR, 2'd3, 1'b0);
        total++;
        if (err_vec !== 8'h0C || err_cnt !== 16'd2) begin
            bad++;
            $display("FAIL trcd_boundary_wr: got vec=%h cnt=%0d want 0c 2", err_vec, err_cnt);
        end
        tick(ACT, 2'd1, 1'b0);
        total++;
        if (err_vec !== 8'h1C || err_cnt !== 16'd3) begin
            bad++;
            $display("FAIL act_open_bank: got vec=%h cnt=%0d want 1c 3", err_vec, err_cnt);
        end
        tick(PRE, 2'd0, 1'b1);
        tick(ACT, 2'd2, 1'b0);
        total++;
        if (err_vec !== 8'h1E || err_cnt !== 16'd4) begin
            bad++;
            $display("FAIL trp_after_pre_all: got vec=%h cnt=%0d want 1e 4", err_vec, err_cnt);
        end
        tick(PRE, 2'd2, 1'b0);
        tick(NOP, 2'd0, 1'b0);
        tick(ACT, 2'd2, 1'b0);
        total++;
        if (err_cnt !== 16'd4 || first_err !== 3'd2) begin
            bad++;
            $display("FAIL trp_boundary: got cnt=%0d fe=%0d want 4 2", err_cnt, first_err);
        end
        tick(PRE, 2'd0, 1'b1);
        nops(2);
    endtask

    task automatic test_clear();
        err_clr = 1'b1;
        tick(NOP, 2'd0, 1'b0);
        total++;
        if (err_vec !== 8'h00 || err_cnt !== 16'd0 || first_err_vld !== 1'b0 || init_done !== 1'b1)
        begin
            bad++;
            $display("FAIL err_clr: got vec=%h cnt=%0d vld=%b done=%b want 00 0 0 1",
                     err_vec, err_cnt, first_err_vld, init_done);
        end
    endtask

    task automatic test_cas();
        refresh();
        cfg_cas = 3'd3;
        tick(ACT, 2'd0, 1'b0);
        nops(2);
        auto_rv = 1'b0;
        man_rv = 1'b0;
        tick(RD, 2'd0, 1'b0);
        tick(NOP, 2'd0, 1'b0);
        man_rv = 1'b1;
        tick(NOP, 2'd0, 1'b0);
        total++;
        if (err_vec !== 8'h80 || err_cnt !== 16'd1) begin
            bad++;
            $display("FAIL cas_early_strobe: got vec=%h cnt=%0d want 80 1", err_vec, err_cnt);
        end
        man_rv = 1'b0;
        tick(NOP, 2'd0, 1'b0);
        total++;
        if (err_cnt !== 16'd2 || first_err !== 3'd7) begin
            bad++;
            $display("FAIL cas_missing_strobe: got cnt=%0d fe=%0d want 2 7", err_cnt, first_err);
        end
        auto_rv = 1'b1;
        tick(RD, 2'd0, 1'b0);
        nops(4);
        total++;
        if (err_cnt !== 16'd2) begin
            bad++;
            $display("FAIL cas3_legal: got cnt=%0d want 2", err_cnt);
        end
        cfg_cas = 3'd4;
        nops(2);
        cfg_cas = 3'd1;
        tick(NOP, 2'd0, 1'b0);
        cfg_cas = 3'd2;
        tick(NOP, 2'd0, 1'b0);
        total++;
        if (err_cnt !== 16'd5) begin
            bad++;
            $display("FAIL cas_illegal_cfg: got cnt=%0d want 5", err_cnt);
        end
        tick(PRE, 2'd0, 1'b1);
        nops(2);
    endtask

    task automatic test_refresh_interval();
        refresh();
        tick(ACT, 2'd0, 1'b0);
        nops(247);
        total++;
        if (err_vec !== 8'h00) begin
            bad++;
            $display("FAIL rfsh_before_max: got vec=%h want 00", err_vec);
        end
        tick(NOP, 2'd0, 1'b0);
        total++;
        if (err_vec !== 8'h40 || err_cnt !== 16'd1 || first_err !== 3'd6) begin
            bad++;
            $display("FAIL rfsh_at_max: got vec=%h cnt=%0d fe=%0d want 40 1 6",
                     err_vec, err_cnt, first_err);
        end
        nops(44);
        total++;
        if (err_cnt !== 16'd1) begin
            bad++;
            $display("FAIL rfsh_once: got cnt=%0d want 1", err_cnt);
        end
        tick(REF, 2'd0, 1'b0);
        total++;
        if (err_vec !== 8'h50 || err_cnt !== 16'd2 || first_err !== 3'd6) begin
            bad++;
            $display("FAIL ref_bank_open: got vec=%h cnt=%0d fe=%0d want 50 2 6",
                     err_vec, err_cnt, first_err);
        end
        nops(7);
        tick(PRE, 2'd0, 1'b1);
        nops(2);
    endtask

    task automatic test_clr_trfc();
        tick(REF, 2'd0, 1'b0);
        total++;
        if (err_vec !== 8'h50 || err_cnt !== 16'd2) begin
            bad++;
            $display("FAIL ref_legal: got vec=%h cnt=%0d want 50 2", err_vec, err_cnt);
        end
        nops(2);
        err_clr = 1'b1;
        tick(PRE, 2'd0, 1'b0);
        total++;
        if (err_vec !== 8'h20 || err_cnt !== 16'd1 || first_err !== 3'd5 || first_err_vld !== 1'b1)
        begin
            bad++;
            $display("FAIL clr_with_trfc: got vec=%h cnt=%0d fe=%0d vld=%b want 20 1 5 1",
                     err_vec, err_cnt, first_err, first_err_vld);
        end
        nops(7);
        tick(REF, 2'd0, 1'b0);
        nops(6);
        tick(PRE, 2'd1, 1'b0);
        total++;
        if (err_vec !== 8'h20 || err_cnt !== 16'd1) begin
            bad++;
            $display("FAIL trfc_boundary: got vec=%h cnt=%0d want 20 1", err_vec, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_init_boundary();
        test_early_act();
        test_init_legal();
        test_bank_timing();
        test_clear();
        test_cas();
        test_clear();
        test_refresh_interval();
        test_clr_trfc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_protocol_monitor.md
Name: sdram_protocol_monitor

Overview:
- Synthesizable, parametrised SDRAM command-bus monitor.
- Taps the controller-to-SDRAM pins in the SDRAM clock domain and checks the following:
  - power-up init sequence
  - per-bank open/close state
  - tRP, tRCD and tRFC
  - refresh interval
  - CAS-latency read-data timing
- Reports each violation as a sticky error bit, a saturating error count and a latched first-error code. It serves both silicon debug and simulation.
- Generalises the fixed-timing checks to N banks, programmable CAS latency and run-time clear.

Parameters:
- NUM_BANKS, 4, number of SDRAM banks tracked.
- BA_W, 2, bank address width; must equal clog2(NUM_BANKS).
- INIT_NOP, 10000, minimum NOP/inhibit cycles after reset before the first PRECHARGE.
- TRP, 2, minimum cycles from PRECHARGE to ACTIVATE on the same bank.
- TRCD, 2, minimum cycles from ACTIVATE to READ/WRITE on the same bank.
- TRFC, 7, cycles after REFRESH during which only NOP/inhibit is legal.
- RFSH_MAX, 256, maximum cycles between consecutive REFRESH commands.
- TMR_W, 16, width of internal timers.
- CNT_W, 16, width of err_cnt.

Ports:
- sdram_clk  in  1  monitor clock, same as the controller's SDRAM clock.
- sdram_rst_n  in  1  asynchronous active-low reset.
- sdram_cs_n  in  1  chip select; high means inhibit, treated as NOP.
- sdram_ras_n  in  1  RAS.
- sdram_cas_n  in  1  CAS.
- sdram_we_n  in  1  WE.
- sdram_ba  in  BA_W  bank address.
- sdram_a10  in  1  address bit 10; selects precharge-all when high on PRECHARGE.
- sdram_rd_valid  in  1  controller's read-data capture strobe.
- cfg_cas  in  3  programmed CAS latency; legal values are 2 and 3.
- err_clr  in  1  synchronous clear of all error state.
- init_done  out  1  high once the init sequence completes.
- err_vec  out  8  sticky error flags.
- err_cnt  out  CNT_W  saturating count of error events.
- first_err  out  3  index of the first error bit set since reset or clear.
- first_err_vld  out  1  first_err is valid.

Behaviour:
- Reset:
  - All outputs are 0.
  - All banks are closed.
  - Bank timers are preloaded to satisfied (saturated).
  - The FSM is in PWR.
- Command decode when cs_n is low, from {ras_n, cas_n, we_n}:
  - 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS.
  - cs_n high counts as NOP.
- Init FSM:
  - PWR: count NOPs. A non-NOP before INIT_NOP cycles sets err bit0 (INIT) and moves to WAIT_PRE.
  - WAIT_PRE: NOPs hold; PRE moves to WAIT_REF1; any other command sets bit0.
  - WAIT_REF1 to WAIT_REF2 to WAIT_MRS: each advances on REF, REF, MRS respectively. NOPs hold. Other commands set bit0 and the state holds.
  - WAIT_MRS, on MRS: go to RUN. init_done rises the cycle after MRS is sampled.
  - RUN is terminal until reset.
- RUN checks (per-bank state and timers are indexed by sdram_ba):
  - bit1 TRP: ACT when the bank's PRE timer is < TRP. PRE with a10 high restarts all bank timers.
  - bit2 TRCD: READ/WRITE when the bank's ACT timer is < TRCD.
  - bit3 CLOSED: READ/WRITE to a closed bank.
  - bit4 OPEN:
    - ACT to an already-open bank.
    - REF while any bank is open.
  - bit5 TRFC: any non-NOP within TRFC cycles after REF.
  - bit6 RFSH:
    - The refresh timer reaches RFSH_MAX without a REF. Flagged once per overrun; re-armed by the next REF.
    - The refresh timer starts at the second init REF.
  - bit7 CAS:
    - A READ pushes a marker into a 4-deep shift register.
    - rd_valid must be high exactly cfg_cas cycles after the READ.
    - A missing strobe or an unexpected strobe is an error.
    - cfg_cas not equal to 2 or 3 while in RUN also sets bit7 every cycle.
- Bank state updates:
  - PRE closes the addressed bank, or all banks when a10 is high.
  - ACT opens the bank.
  - Updates take effect in the same cycle the command is checked; the check uses the pre-command state.
- Error bookkeeping:
  - err_vec bits are set on the cycle after detection.
  - err_cnt adds the number of bits detected that cycle and saturates at all-ones.
  - first_err latches the lowest detected index when first_err_vld is 0.
- err_clr:
  - Zeroes err_vec, err_cnt and first_err_vld.
  - A detection in the same cycle as err_clr wins: its bits, count and first_err are applied after the clear.
  - err_clr does not affect the FSM, bank state or timers.
- Timers saturate at all-ones; there is no wrap-around.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Optional Feature:
- SDRAM_MON_DISPLAY_EN: when defined, a non-synthesizable block issues $error with the simulation time, error name and bank on every detection.
- When undefined, the block is purely synthesizable and silent. Register behaviour is identical in both cases.

Test Plan:
- Legal init: reset, 10000 NOP, PRE(a10=1), 3 NOP, REF, 7 NOP, REF, 7 NOP, MRS → init_done=1 the cycle after MRS; err_vec=0x00.
- Early ACT: ACT at NOP cycle 50 → err_vec=0x01, err_cnt=1, first_err=0.
- ACT bank1, then READ bank1 one cycle later with TRCD=2 → bit2 set. READ bank2 (closed) → bit3 set. err_cnt=2, first_err=2.
- cfg_cas=3, READ at cycle t, rd_valid at t+2 only → bit7 set; err_cnt increments by 2 (unexpected strobe, then missing strobe).
- No REF for 300 cycles in RUN → bit6 set once at timer=256; a following REF with a bank open → bit4 set.
- err_clr coincident with TRFC violation (command 3 cycles after REF) → err_vec=0x20, err_cnt=1, first_err=5.
